// File: rtl/serial_sub4_if.sv
// Operand, result and handshake bundle for the bit-serial 4-bit subtractor.
// The sequencer side is master; the subtractor side is slave.
interface serial_sub4_if;
  logic start;
  logic a3, a2, a1, a0;
  logic b3, b2, b1, b0;
  logic d3, d2, d1, d0;
  logic bw4, bw3, bw2, bw1;
  logic busy;
  logic done;

  modport master (
    output start, a3, a2, a1, a0, b3, b2, b1, b0,
    input  d3, d2, d1, d0, bw4, bw3, bw2, bw1, busy, done
  );

  modport slave (
    input  start, a3, a2, a1, a0, b3, b2, b1, b0,
    output d3, d2, d1, d0, bw4, bw3, bw2, bw1, busy, done
  );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor D = A - B, LSB first, one bit per STEP_CYCLES
// clocks, with the ripple borrow held in a flop and exposed as registered taps.
module serial_sub4 #(
  parameter int STEP_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  serial_sub4_if.slave bus
);

  localparam logic [1:0] TERM = 2'(STEP_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nx;
  logic       accept, bit_en, last;

  logic [3:0] a_q, b_q;
  logic [3:0] d_q;
  logic [3:0] bw_q;      // bw_q[i] is the borrow out of bit i (bw_{i+1})
  logic       borrow;
  logic [1:0] idx;
  logic [1:0] cnt;
  logic       busy_q, done_q;

  function automatic logic diff_bit(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    bit_en   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == TERM) begin
          bit_en = 1'b1;
          if (idx == 2'd3) begin
            last     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      bw_q   <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q    <= {bus.a3, bus.a2, bus.a1, bus.a0};
        b_q    <= {bus.b3, bus.b2, bus.b1, bus.b0};
        d_q    <= '0;
        bw_q   <= '0;
        borrow <= 1'b0;
        idx    <= '0;
        cnt    <= '0;
        busy_q <= 1'b1;
      end else if (state == RUN) begin
        if (bit_en) begin
          d_q[idx]  <= diff_bit(a_q[idx], b_q[idx], borrow);
          bw_q[idx] <= borrow_bit(a_q[idx], b_q[idx], borrow);
          borrow    <= borrow_bit(a_q[idx], b_q[idx], borrow);
          idx       <= 2'(idx + 2'd1);
          cnt       <= '0;
          if (last) busy_q <= 1'b0;
        end else begin
          cnt <= 2'(cnt + 2'd1);
        end
      end
    end
  end

  assign {bus.d3, bus.d2, bus.d1, bus.d0}     = d_q;
  assign {bus.bw4, bus.bw3, bus.bw2, bus.bw1} = bw_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4: vector table at one cycle per bit, handshake
// and reset corner sequences, and a three-cycles-per-bit latency run.
module tb_serial_sub4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_sub4_if if1 ();
  serial_sub4_if if3 ();

  serial_sub4 #(.STEP_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  serial_sub4 #(.STEP_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [3:0] d_1, bw_1, d_3, bw_3;
  assign d_1  = {if1.d3, if1.d2, if1.d1, if1.d0};
  assign bw_1 = {if1.bw4, if1.bw3, if1.bw2, if1.bw1};
  assign d_3  = {if3.d3, if3.d2, if3.d1, if3.d0};
  assign bw_3 = {if3.bw4, if3.bw3, if3.bw2, if3.bw1};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic [3:0] bw;   // {bw4, bw3, bw2, bw1}
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic s, input logic [3:0] a, input logic [3:0] b);
    if1.start = s;
    {if1.a3, if1.a2, if1.a1, if1.a0} = a;
    {if1.b3, if1.b2, if1.b1, if1.b0} = b;
  endtask

  task automatic drive3(input logic s, input logic [3:0] a, input logic [3:0] b);
    if3.start = s;
    {if3.a3, if3.a2, if3.a1, if3.a0} = a;
    {if3.b3, if3.b2, if3.b1, if3.b0} = b;
  endtask

  // One full operation on the single-cycle instance with per-cycle handshake checks.
  task automatic run1(input string tag, input vec_t v);
    drive1(1'b1, v.a, v.b);
    tick();
    drive1(1'b0, 4'hF ^ v.a, 4'hF ^ v.b);
    check({tag, " busy_e0"}, {7'd0, if1.busy}, 8'd1);
    check({tag, " d_cleared"}, {4'd0, d_1}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check({tag, " busy_run"}, {7'd0, if1.busy}, 8'd1);
      check({tag, " done_early"}, {7'd0, if1.done}, 8'd0);
      if (k == 1) check({tag, " upper_bits_zero"}, {4'd0, d_1 & 4'b1110}, 8'd0);
    end
    tick();
    check({tag, " done"}, {7'd0, if1.done}, 8'd1);
    check({tag, " busy_low"}, {7'd0, if1.busy}, 8'd0);
    check({tag, " d"}, {4'd0, d_1}, {4'd0, v.d});
    check({tag, " bw"}, {4'd0, bw_1}, {4'd0, v.bw});
    tick();
    check({tag, " done_pulse"}, {7'd0, if1.done}, 8'd0);
    check({tag, " d_hold"}, {4'd0, d_1}, {4'd0, v.d});
  endtask

  initial begin
    int n;
    vecs[0] = '{a: 4'b0101, b: 4'b0011, d: 4'b0010, bw: 4'b0010};
    vecs[1] = '{a: 4'b0011, b: 4'b0101, d: 4'b1110, bw: 4'b1100};
    vecs[2] = '{a: 4'b0000, b: 4'b0001, d: 4'b1111, bw: 4'b1111};
    vecs[3] = '{a: 4'b1111, b: 4'b1111, d: 4'b0000, bw: 4'b0000};
    vecs[4] = '{a: 4'b1000, b: 4'b0001, d: 4'b0111, bw: 4'b0111};
    vecs[5] = '{a: 4'b1010, b: 4'b0101, d: 4'b0101, bw: 4'b0101};
    vecs[6] = '{a: 4'b0000, b: 4'b1111, d: 4'b0001, bw: 4'b1111};
    vecs[7] = '{a: 4'b0110, b: 4'b0110, d: 4'b0000, bw: 4'b0000};

    drive1(1'b0, 4'h0, 4'h0);
    drive3(1'b0, 4'h0, 4'h0);
    tick();
    tick();
    check("reset busy", {7'd0, if1.busy}, 8'd0);
    check("reset done", {7'd0, if1.done}, 8'd0);
    check("reset d", {4'd0, d_1}, 8'd0);
    check("reset bw", {4'd0, bw_1}, 8'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run1($sformatf("vec%0d", i), vecs[i]);

    // start re-pulsed while busy must be ignored
    drive1(1'b1, 4'b0101, 4'b0011);
    tick();
    drive1(1'b0, 4'b0101, 4'b0011);
    tick();
    drive1(1'b1, 4'b0000, 4'b0001);
    tick();
    drive1(1'b0, 4'b0000, 4'b0001);
    check("restart busy", {7'd0, if1.busy}, 8'd1);
    tick();
    tick();
    check("restart done", {7'd0, if1.done}, 8'd1);
    check("restart d_kept", {4'd0, d_1}, 8'b0010);
    check("restart bw_kept", {4'd0, bw_1}, 8'b0010);

    // start held in the done cycle is accepted
    drive1(1'b1, 4'b0011, 4'b0101);
    tick();
    drive1(1'b0, 4'b0000, 4'b0000);
    check("doneacc busy", {7'd0, if1.busy}, 8'd1);
    check("doneacc done_drop", {7'd0, if1.done}, 8'd0);
    check("doneacc d_clear", {4'd0, d_1}, 8'd0);
    check("doneacc bw_clear", {4'd0, bw_1}, 8'd0);
    tick(); tick(); tick(); tick();
    check("doneacc done", {7'd0, if1.done}, 8'd1);
    check("doneacc d", {4'd0, d_1}, 8'b1110);
    check("doneacc bw", {4'd0, bw_1}, 8'b1100);
    tick();

    // asynchronous reset after bit 1 aborts without a done pulse
    drive1(1'b1, 4'b0000, 4'b0001);
    tick();
    drive1(1'b0, 4'b0000, 4'b0001);
    tick();
    tick();
    check("abort partial d", {4'd0, d_1}, 8'b0011);
    #2 rst = 1'b1;
    #1;
    check("abort d", {4'd0, d_1}, 8'd0);
    check("abort bw", {4'd0, bw_1}, 8'd0);
    check("abort busy", {7'd0, if1.busy}, 8'd0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if1.done || if1.busy) n++;
    end
    check("abort no_activity", 8'(n), 8'd0);
    run1("post_reset", vecs[1]);

    // three cycles per bit
    drive3(1'b1, 4'b1000, 4'b0001);
    tick();
    drive3(1'b0, 4'b0000, 4'b0000);
    tick();
    tick();
    check("s3 bit0_not_yet", {4'd0, d_3}, 8'd0);
    tick();
    check("s3 bit0_written", {4'd0, d_3}, 8'b0001);
    n = 3;
    while (!if3.done && n < 20) begin
      tick();
      n++;
    end
    check("s3 latency", 8'(n), 8'd12);
    check("s3 d", {4'd0, d_3}, 8'b0111);
    check("s3 bw", {4'd0, bw_3}, 8'b0111);
    check("s3 bw4", {7'd0, if3.bw4}, 8'd0);
    tick();
    check("s3 done_pulse", {7'd0, if3.done}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
